// File: rtl/mips_ctrl_defs.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// FSM states, PC source, memory address select and trap cause codes.
package mips_ctrl_defs;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ADDR_SEL_PC  = 2'b00,
        ADDR_SEL_ALU = 2'b01,
        ADDR_SEL_RT  = 2'b10
    } addr_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_BUS     = 2'b10
    } trap_cause_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts memory-request wait cycles; expired_o flags that the count has
// reached the supplied limit.
module mem_timeout_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == limit_i);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: shares one memory port between
// fetch and data access and drives the register/memory strobes and traps.
module mips_multicycle_ctrl
    import mips_ctrl_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             mem_read_i,
    input  logic             word_we_i,
    input  logic             byte_we_i,
    input  logic             addm_i,
    input  logic             writeenable_i,
    input  logic             except_i,
    input  logic [1:0]       control_type_i,
    input  logic             mem_ready_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output logic             pc_trap_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [1:0]       mem_addr_sel_o,
    output logic             mdr_we_o,
    output logic             rf_we_o,
    output logic             wb_sel_o,
    output logic             alu_b_mdr_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT);

    state_e            state_q;
    state_e            state_d;
    trap_cause_e       cause_q;
    trap_cause_e       cause_d;
    logic [CNT_W-1:0]  instret_q;
    logic [CNT_W-1:0]  instret_d;
    logic              retire_c;
    logic              expired_c;
    logic              timeout_c;
    logic              mem_access_c;
    logic              store_c;

    assign mem_access_c = mem_read_i | word_we_i | byte_we_i | addm_i;
    assign store_c      = word_we_i | byte_we_i;
    // mem_ready on the limit cycle wins over the timeout
    assign timeout_c    = expired_c & ~mem_ready_i;

    // Wait counter restarts on every state change, i.e. on entry to FETCH/MEM
    mem_timeout_counter #(
        .W (TO_W)
    ) u_timeout (
        .clk_i     (clock_i),
        .rst_i     (reset_i),
        .clear_i   (state_d != state_q),
        .enable_i  (mem_req_o & ~mem_ready_i),
        .limit_i   (TO_W'(MEM_TIMEOUT - 1)),
        .expired_o (expired_c)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_FETCH;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            ST_DECODE: begin
                if (except_i) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (mem_access_c) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_FETCH;
            ST_MEM: begin
                if (mem_ready_i) begin
                    state_d = store_c ? ST_FETCH : ST_WB;
                end else if (timeout_c) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_src_o       = PC_SRC_SEQ;
        pc_trap_o      = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = ADDR_SEL_PC;
        mdr_we_o       = 1'b0;
        rf_we_o        = 1'b0;
        wb_sel_o       = 1'b0;
        alu_b_mdr_o    = 1'b0;
        trap_o         = 1'b0;
        retire_c       = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                ST_FETCH: begin
                    mem_req_o = 1'b1;
                    ir_we_o   = mem_ready_i;
                end
                ST_DECODE: ;
                ST_EXEC: begin
                    rf_we_o  = writeenable_i;
                    pc_we_o  = 1'b1;
                    pc_src_o = control_type_i;
                    retire_c = 1'b1;
                end
                ST_MEM: begin
                    mem_req_o      = 1'b1;
                    mem_we_o       = store_c;
                    mem_addr_sel_o = addm_i ? ADDR_SEL_RT : ADDR_SEL_ALU;
                    if (mem_ready_i) begin
                        pc_we_o  = store_c;
                        retire_c = store_c;
                        mdr_we_o = ~store_c;
                    end
                end
                ST_WB: begin
                    rf_we_o     = 1'b1;
                    wb_sel_o    = mem_read_i;
                    alu_b_mdr_o = addm_i;
                    pc_we_o     = 1'b1;
                    retire_c    = 1'b1;
                end
                ST_TRAP: begin
                    trap_o    = 1'b1;
                    pc_we_o   = 1'b1;
                    pc_trap_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instret_d    = retire_c ? instret_q + CNT_W'(1) : instret_q;
    assign instret_o    = reset_i ? '0 : instret_q;
    assign trap_cause_o = reset_i ? CAUSE_NONE : cause_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (MEM_TIMEOUT = 4).
module tb_mips_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read, word_we, byte_we, addm, writeenable, except;
    logic [1:0]  control_type;
    logic        mem_ready;
    logic        ir_we, pc_we, pc_trap, mem_req, mem_we, mdr_we, rf_we;
    logic        wb_sel, alu_b_mdr, trap;
    logic [1:0]  pc_src, mem_addr_sel, trap_cause;
    logic [31:0] instret;
    logic [15:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    assign outs = {ir_we, pc_we, pc_src, pc_trap, mem_req, mem_we, mem_addr_sel,
                   mdr_we, rf_we, wb_sel, alu_b_mdr, trap, trap_cause};

    mips_multicycle_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .mem_read_i     (mem_read),
        .word_we_i      (word_we),
        .byte_we_i      (byte_we),
        .addm_i         (addm),
        .writeenable_i  (writeenable),
        .except_i       (except),
        .control_type_i (control_type),
        .mem_ready_i    (mem_ready),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .pc_src_o       (pc_src),
        .pc_trap_o      (pc_trap),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_sel_o (mem_addr_sel),
        .mdr_we_o       (mdr_we),
        .rf_we_o        (rf_we),
        .wb_sel_o       (wb_sel),
        .alu_b_mdr_o    (alu_b_mdr),
        .trap_o         (trap),
        .trap_cause_o   (trap_cause),
        .instret_o      (instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dec(input logic rd, input logic sw, input logic sb, input logic am,
                           input logic we, input logic ex, input logic [1:0] ct);
        mem_read     = rd;
        word_we      = sw;
        byte_we      = sb;
        addm         = am;
        writeenable  = we;
        except       = ex;
        control_type = ct;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        chk("reset_outs", 32'(outs), 32'h0);
        chk("reset_instret", instret, 32'd0);

        // add with mem_ready high throughout
        reset     = 1'b0;
        mem_ready = 1'b1;
        set_dec(0, 0, 0, 0, 1, 0, 2'b00);
        #1;
        chk("add_fetch_req", 32'(mem_req), 32'd1);
        chk("add_fetch_irwe", 32'(ir_we), 32'd1);
        chk("add_fetch_sel", 32'(mem_addr_sel), 32'd0);
        tick();
        chk("add_decode_outs", 32'(outs), 32'h0);
        tick();
        chk("add_exec_rfwe", 32'(rf_we), 32'd1);
        chk("add_exec_pcwe", 32'(pc_we), 32'd1);
        chk("add_exec_pcsrc", 32'(pc_src), 32'd0);
        chk("add_exec_instret", instret, 32'd0);
        tick();
        chk("add_done_instret", instret, 32'd1);
        chk("add_done_req", 32'(mem_req), 32'd1);

        // lw with mem_ready two cycles late in MEM
        set_dec(1, 0, 0, 0, 1, 0, 2'b00);
        #1;
        chk("lw_fetch_irwe", 32'(ir_we), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("lw_decode_outs", 32'(outs), 32'h0);
        tick();
        chk("lw_mem1_req", 32'(mem_req), 32'd1);
        chk("lw_mem1_sel", 32'(mem_addr_sel), 32'd1);
        chk("lw_mem1_mdrwe", 32'(mdr_we), 32'd0);
        tick();
        chk("lw_mem2_mdrwe", 32'(mdr_we), 32'd0);
        chk("lw_mem2_we", 32'(mem_we), 32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("lw_mem3_mdrwe", 32'(mdr_we), 32'd1);
        chk("lw_mem3_pcwe", 32'(pc_we), 32'd0);
        tick();
        chk("lw_wb_mdrwe", 32'(mdr_we), 32'd0);
        chk("lw_wb_rfwe", 32'(rf_we), 32'd1);
        chk("lw_wb_wbsel", 32'(wb_sel), 32'd1);
        chk("lw_wb_pcwe", 32'(pc_we), 32'd1);
        chk("lw_wb_req", 32'(mem_req), 32'd0);
        tick();
        chk("lw_done_instret", instret, 32'd2);
        chk("lw_done_req", 32'(mem_req), 32'd1);

        // addm: operand from M[rt]
        set_dec(0, 0, 0, 1, 1, 0, 2'b00);
        tick();
        tick();
        chk("addm_mem_sel", 32'(mem_addr_sel), 32'd2);
        chk("addm_mem_mdrwe", 32'(mdr_we), 32'd1);
        chk("addm_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("addm_wb_alub", 32'(alu_b_mdr), 32'd1);
        chk("addm_wb_wbsel", 32'(wb_sel), 32'd0);
        chk("addm_wb_rfwe", 32'(rf_we), 32'd1);
        tick();
        chk("addm_done_instret", instret, 32'd3);

        // sw retires straight out of MEM
        set_dec(0, 1, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        chk("sw_mem_we", 32'(mem_we), 32'd1);
        chk("sw_mem_sel", 32'(mem_addr_sel), 32'd1);
        chk("sw_mem_rfwe", 32'(rf_we), 32'd0);
        chk("sw_mem_pcwe", 32'(pc_we), 32'd1);
        chk("sw_mem_mdrwe", 32'(mdr_we), 32'd0);
        tick();
        chk("sw_done_instret", instret, 32'd4);
        chk("sw_done_req", 32'(mem_req), 32'd1);

        // jr: pc_src follows control_type
        set_dec(0, 0, 0, 0, 0, 0, 2'b11);
        tick();
        tick();
        chk("jr_exec_pcsrc", 32'(pc_src), 32'd3);
        chk("jr_exec_rfwe", 32'(rf_we), 32'd0);
        tick();
        chk("jr_done_instret", instret, 32'd5);

        // illegal instruction
        set_dec(0, 0, 0, 0, 1, 1, 2'b00);
        tick();
        tick();
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_pctrap", 32'(pc_trap), 32'd1);
        chk("ill_pcwe", 32'(pc_we), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_rfwe", 32'(rf_we), 32'd0);
        tick();
        chk("ill_after_trap", 32'(trap), 32'd0);
        chk("ill_after_req", 32'(mem_req), 32'd1);
        chk("ill_after_cause", 32'(trap_cause), 32'd1);
        chk("ill_instret", instret, 32'd5);

        // fetch timeout: four unanswered request cycles
        set_dec(0, 0, 0, 0, 0, 0, 2'b00);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_wait%0d", i), {30'd0, mem_req, trap}, 32'd2);
            tick();
        end
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd2);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_pctrap", 32'(pc_trap), 32'd1);
        tick();
        chk("to_refetch", 32'(mem_req), 32'd1);
        chk("to_instret", instret, 32'd5);

        // mem_ready on the limit cycle beats the timeout
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lim_irwe", 32'(ir_we), 32'd1);
        chk("lim_trap", 32'(trap), 32'd0);
        tick();
        chk("lim_decode_outs", 32'(outs), 32'h0002);
        tick();
        chk("lim_exec_pcwe", 32'(pc_we), 32'd1);
        tick();
        chk("lim_instret", instret, 32'd6);

        // reset asserted while waiting in MEM
        set_dec(1, 0, 0, 0, 1, 0, 2'b00);
        tick();
        mem_ready = 1'b0;
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", 32'(outs), 32'h0);
        chk("rst_mid_instret", instret, 32'd0);
        tick();
        chk("rst_held_outs", 32'(outs), 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_rel_req", 32'(mem_req), 32'd1);
        chk("rst_rel_sel", 32'(mem_addr_sel), 32'd0);
        chk("rst_rel_mdrwe", 32'(mdr_we), 32'd0);
        chk("rst_rel_cause", 32'(trap_cause), 32'd0);
        chk("rst_rel_instret", instret, 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst_rel_irwe", 32'(ir_we), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle timing so that instruction fetch and data access share one memory port with a ready handshake.
- Consumes the per-instruction control bits from mips_decode (mem_read, word_we, byte_we, addm, writeenable, except, control_type) and produces the register/memory write strobes, the address mux select and the trap pulse.
- Sits between mips_decode and the datapath registers (PC, IR, MDR, register file).

Parameters:
- MEM_TIMEOUT, 16: cycles mem_req may stay high without mem_ready before a bus-error trap; legal range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  from decoder: lw/lbu.
- word_we  in  1  from decoder: sw.
- byte_we  in  1  from decoder: sb.
- addm  in  1  from decoder: addm (rd = rs + M[rt]).
- writeenable  in  1  from decoder: instruction writes rd/rt.
- except  in  1  from decoder: unrecognised opcode/funct.
- control_type  in  2  from decoder: 00 fallthrough, 01 branch, 10 jump, 11 jr.
- mem_ready  in  1  memory completes the current request this cycle.
- ir_we  out  1  capture fetched word into IR.
- pc_we  out  1  update PC.
- pc_src  out  2  PC source: control_type encoding; forced 00 on memory paths.
- pc_trap  out  1  PC loads exception vector (overrides pc_src).
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- mem_addr_sel  out  2  00 PC, 01 ALU result, 10 rt register value.
- mdr_we  out  1  capture memory read data into MDR.
- rf_we  out  1  register-file write strobe.
- wb_sel  out  1  0 ALU result, 1 MDR.
- alu_b_mdr  out  1  ALU operand B taken from MDR (addm).
- trap  out  1  one-cycle pulse on exception.
- trap_cause  out  2  00 none, 01 illegal instruction, 10 bus timeout; held until next trap or reset.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - Next state is FETCH.
  - All outputs are 0 while reset is high, including mem_req; trap_cause and instret are cleared.
  - A reset asserted mid-request abandons the request with no strobe. The first post-reset cycle is FETCH with mem_req=1.
- Outputs are combinational from state, plus mem_ready and the decoder inputs where noted below.
- States:
  - FETCH:
    - mem_req=1, mem_addr_sel=00, mem_we=0.
    - On mem_ready: ir_we=1, go to DECODE. Otherwise stay.
  - DECODE:
    - No strobes. This cycle allows decoder and register-file read settling.
    - If except: go to TRAP with cause 01.
    - Else if mem_read|word_we|byte_we|addm: go to MEM.
    - Else: go to EXEC.
  - EXEC:
    - rf_we=writeenable, wb_sel=0, pc_we=1, pc_src=control_type.
    - instret increments. Go to FETCH.
    - Branch-not-taken arrives as control_type 00 from the decoder; no special handling.
  - MEM:
    - mem_req=1, mem_we=word_we|byte_we.
    - mem_addr_sel=10 if addm, else 01.
    - On mem_ready with a store: pc_we=1, pc_src=00, instret increments, go to FETCH.
    - On mem_ready with a load or addm: mdr_we=1, go to WB.
  - WB:
    - rf_we=1, wb_sel = mem_read ? 1 : 0, alu_b_mdr=addm.
    - pc_we=1, pc_src=00, instret increments. Go to FETCH.
  - TRAP:
    - trap=1, pc_we=1, pc_trap=1; trap_cause is updated.
    - instret does not increment. Go to FETCH.
- Timeout:
  - A counter clears on entry to FETCH or MEM and increments each cycle that mem_req=1 and mem_ready=0.
  - When the counter reaches MEM_TIMEOUT-1 with mem_ready still 0, go to TRAP with cause 10; mem_req drops in the TRAP cycle.
  - mem_ready in the same cycle as the limit wins: the normal transition is taken.
- mem_ready is ignored in DECODE, EXEC, WB and TRAP.
- The strobes ir_we, mdr_we, rf_we, pc_we and trap are each high for at most one cycle per instruction.
- instret wraps modulo 2^CNT_W.
- Minimum latency per instruction (mem_ready in the first request cycle): ALU/branch/jump 3 cycles, store 3, load/addm 4, illegal 3.

Decomposition:
- Package mips_ctrl_defs holds:
  - the state encoding: FETCH, DECODE, EXEC, MEM, WB, TRAP;
  - the pc_src codes;
  - the mem_addr_sel codes;
  - the trap_cause codes.
- One sub-module: mem_timeout_counter (clear, enable, limit in; expired out), width derived from MEM_TIMEOUT.

Test Plan:
- add, mem_ready high throughout:
  - FETCH -> DECODE -> EXEC.
  - rf_we=1 and pc_we=1 with pc_src=00 in cycle 3.
  - instret 0 -> 1.
- lw, mem_ready delayed 2 cycles in MEM:
  - mdr_we exactly once.
  - Next cycle rf_we=1, wb_sel=1; 6 cycles total.
- addm:
  - mem_addr_sel=10 in MEM.
  - WB has alu_b_mdr=1, wb_sel=0.
  - sw then shows mem_we=1, rf_we=0.
- except=1 in DECODE:
  - TRAP next cycle: trap=1, pc_trap=1, trap_cause=01.
  - instret unchanged; then FETCH.
- mem_ready held low in FETCH with MEM_TIMEOUT=4:
  - trap with cause 10 after 4 request cycles.
  - Repeat with mem_ready arriving in cycle 4: no trap, ir_we=1.
- reset asserted in MEM mid-wait:
  - All outputs 0 while reset is high.
  - instret cleared.
  - First cycle after release: FETCH with mem_req=1, mem_addr_sel=00.
